// File: rtl/resp_capture_pkg.sv
// Shared types and helpers for the response-capture MISR block: state encoding,
// default feedback polynomial and the single-step MISR update used by RTL and bench.
package resp_capture_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} cap_state_t;

  localparam int MISR_MAX_W = 32;
  localparam logic [15:0] DEFAULT_SIG_POLY = 16'h1021;

  // One MISR step on the low 'width' bits: shift left, fold the feedback taps
  // in when the outgoing MSB is set, then XOR the new data word in.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] fb;
    mask = (width >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
    fb   = sig[5'(width - 1)] ? poly : '0;
    return ((sig << 1) ^ fb ^ data) & mask;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous record FIFO with wrap-bit pointers; 'clr' empties it synchronously
// and takes priority over push/pop. A push into a full FIFO succeeds only with a pop.
module resp_fifo #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the head is forced to zero while empty instead.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/resp_capture_misr.sv
// Response capture: MISR compaction, sweep counter and raw-record FIFO.
// Optional golden truth-table compare is enabled by defining RESP_GOLDEN_CMP_EN.
module resp_capture_misr
  import resp_capture_pkg::*;
#(
  parameter int               VEC_W      = 4,
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] SIG_POLY   = SIG_W'(DEFAULT_SIG_POLY),
  parameter int               FIFO_DEPTH = 16,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [VEC_W-1:0] in_vec,
  input  logic             in_resp,
  output logic             in_ready,
  output logic             out_valid,
  output logic [VEC_W:0]   out_data,
  input  logic             out_ready,
  output logic [SIG_W-1:0] sig,
  output logic [VEC_W:0]   vec_count,
  output logic             done,
  output logic             pass,
  output logic             overflow
`ifdef RESP_GOLDEN_CMP_EN
  ,
  input  logic [2**VEC_W-1:0] golden_tt,
  output logic [VEC_W:0]      mism_count,
  output logic [VEC_W-1:0]    first_mism_vec,
  output logic                first_mism_valid
`endif
);

  localparam logic [VEC_W:0] FULL_COUNT = {1'b1, {VEC_W{1'b0}}};

  cap_state_t       state;
  cap_state_t       state_nxt;
  logic             accept;
  logic             last_accept;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             mism_ok;
  logic [SIG_W-1:0] sig_nxt;

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (vec_count == FULL_COUNT - 1'b1);
  assign fifo_pop    = out_ready && !fifo_empty;
  assign out_valid   = !fifo_empty;

  assign sig_nxt = SIG_W'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'({in_vec, in_resp}),
                                    MISR_MAX_W'(SIG_POLY), SIG_W));

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = CAPTURE;
    end else begin
      case (state)
        CAPTURE: if (last_accept) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    in_ready = (state == CAPTURE);
    done     = (state == DONE);
  end

  // start outranks a same-cycle accept, so that pair never reaches the MISR.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      sig       <= '0;
      vec_count <= '0;
      overflow  <= 1'b0;
    end else if (start) begin
      sig       <= '0;
      vec_count <= '0;
      overflow  <= 1'b0;
    end else if (accept) begin
      sig       <= sig_nxt;
      vec_count <= vec_count + 1'b1;
      if (fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

`ifdef RESP_GOLDEN_CMP_EN
  logic resp_mism;
  assign resp_mism = (in_resp != golden_tt[in_vec]);

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      mism_count       <= '0;
      first_mism_vec   <= '0;
      first_mism_valid <= 1'b0;
    end else if (start) begin
      mism_count       <= '0;
      first_mism_vec   <= '0;
      first_mism_valid <= 1'b0;
    end else if (accept && resp_mism) begin
      mism_count <= mism_count + 1'b1;
      if (!first_mism_valid) begin
        first_mism_vec   <= in_vec;
        first_mism_valid <= 1'b1;
      end
    end
  end

  assign mism_ok = (mism_count == '0);
`else
  assign mism_ok = 1'b1;
`endif

  assign pass = done && (sig == GOLDEN_SIG) && mism_ok;

  // The logger never stalls compaction: a full FIFO just drops the record.
  resp_fifo #(
    .DATA_W(VEC_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CK),
    .rst_n    (reset),
    .clr      (start),
    .push     (accept),
    .push_data({in_vec, in_resp}),
    .pop      (fifo_pop),
    .pop_data (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_resp_capture_misr.sv
// Scoreboard bench for resp_capture_misr: a behavioural model predicts the
// signature, counters and FIFO contents; a monitor pops and compares records.
module tb_resp_capture_misr;
  import resp_capture_pkg::*;

  localparam int          NVEC   = 16;
  localparam int          DEPTH  = 16;
  localparam logic [15:0] GOLDEN = 16'h0000;

  logic        CK = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_vec = '0;
  logic        in_resp = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, done, pass, overflow;
  logic [4:0]  out_data, vec_count;
  logic [15:0] sig;

  logic [4:0]  in_vec5;
  logic        in_ready5, out_valid5, done5, pass5, overflow5;
  logic [5:0]  out_data5, vec_count5;
  logic [15:0] sig5;

`ifdef RESP_GOLDEN_CMP_EN
  logic [15:0] golden_tt = '0;
  logic [31:0] golden_tt5 = '0;
  logic [4:0]  mism_count;
  logic [3:0]  first_mism_vec;
  logic        first_mism_valid;
  logic [5:0]  mism_count5;
  logic [4:0]  first_mism_vec5;
  logic        first_mism_valid5;
`endif

  assign in_vec5 = {1'b0, in_vec};

  always #5 CK = ~CK;

  resp_capture_misr #(.VEC_W(4), .FIFO_DEPTH(DEPTH), .GOLDEN_SIG(GOLDEN)) u_dut (
    .CK(CK), .reset(reset), .start(start), .in_valid(in_valid), .in_vec(in_vec),
    .in_resp(in_resp), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .sig(sig), .vec_count(vec_count), .done(done), .pass(pass),
    .overflow(overflow)
`ifdef RESP_GOLDEN_CMP_EN
    , .golden_tt(golden_tt), .mism_count(mism_count), .first_mism_vec(first_mism_vec),
    .first_mism_valid(first_mism_valid)
`endif
  );

  // Wider sweep instance so more pairs than FIFO entries can be accepted.
  resp_capture_misr #(.VEC_W(5), .FIFO_DEPTH(DEPTH)) u_dut5 (
    .CK(CK), .reset(reset), .start(start), .in_valid(in_valid), .in_vec(in_vec5),
    .in_resp(in_resp), .in_ready(in_ready5), .out_valid(out_valid5), .out_data(out_data5),
    .out_ready(out_ready), .sig(sig5), .vec_count(vec_count5), .done(done5), .pass(pass5),
    .overflow(overflow5)
`ifdef RESP_GOLDEN_CMP_EN
    , .golden_tt(golden_tt5), .mism_count(mism_count5), .first_mism_vec(first_mism_vec5),
    .first_mism_valid(first_mism_valid5)
`endif
  );

  int          n_tests = 0;
  int          n_fail = 0;
  int          pops5 = 0;
  logic [15:0] m_sig;
  int          m_cnt, m_occ, m_mism;
  bit          m_capt, m_done, m_ovf;
  logic [4:0]  expq[$];
  logic [15:0] clean_sig;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input bit capt);
    m_sig = '0; m_cnt = 0; m_occ = 0; m_mism = 0;
    m_capt = capt; m_done = 0; m_ovf = 0;
    expq.delete();
  endtask

  task automatic check_outputs();
    chk("sig", 32'(sig), 32'(m_sig));
    chk("vec_count", 32'(vec_count), 32'(m_cnt));
    chk("done", 32'(done), 32'(m_done));
    chk("in_ready", 32'(in_ready), 32'(m_capt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("out_valid", 32'(out_valid), 32'(m_occ > 0));
    chk("pass", 32'(pass), 32'(m_done && (m_sig == GOLDEN) && (m_mism == 0)));
    if (m_occ > 0 && expq.size() > 0) chk("fifo_head", 32'(out_data), 32'(expq[0]));
  endtask

  // Drive one cycle, predict the effect of the coming edge, then check after it.
  task automatic step(input bit s, input bit v, input logic [3:0] vec, input bit r, input bit ordy);
    bit acc, pop;
    start = s; in_valid = v; in_vec = vec; in_resp = r; out_ready = ordy;
    if (s) begin
      model_clear(1'b1);
    end else begin
      acc = v && m_capt;
      pop = (m_occ > 0) && ordy;
      if (acc) begin
        m_sig = 16'(misr_next(32'(m_sig), 32'({vec, r}), 32'(DEFAULT_SIG_POLY), 16));
        m_cnt++;
`ifdef RESP_GOLDEN_CMP_EN
        if (r != golden_tt[vec]) m_mism++;
`endif
        if (m_cnt == NVEC) begin m_capt = 0; m_done = 1; end
        if (m_occ < DEPTH || pop) begin expq.push_back({vec, r}); m_occ++; end
        else m_ovf = 1;
      end
      if (pop) m_occ--;
    end
    @(posedge CK); #1;
    check_outputs();
  endtask

  always @(negedge CK) begin
    if (reset && !start && out_valid && out_ready) begin
      if (expq.size() == 0) chk("fifo_pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
      else chk("fifo_record", 32'(out_data), 32'(expq.pop_front()));
    end
  end

  always @(negedge CK) begin
    if (reset && !start && out_valid5 && out_ready) pops5++;
  end

  initial begin
    model_clear(1'b0);
    #2 check_outputs();
    @(posedge CK); #1;
    reset = 1'b1;
    step(0, 1, 4'd3, 1, 1);

    // Ordered sweep, resp = vec[0]
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < NVEC; i++) step(0, 1, 4'(i), i[0], 1);
    clean_sig = m_sig;
    chk("sweep_count", 32'(vec_count), 32'd16);
    for (int i = 0; i < 3; i++) step(0, 1, 4'd9, 1, 1);

    // All-zero pairs leave the signature at GOLDEN; one flipped response breaks it
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < NVEC; i++) step(0, 1, 4'd0, 0, 1);
    chk("pass_zero_sweep", 32'(pass), 32'd1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < NVEC; i++) step(0, 1, (i == 7) ? 4'd7 : 4'd0, (i == 7), 1);
    chk("pass_flipped", 32'(pass), 32'd0);

    // FIFO fills without overflow; the wider sweep overflows on pair 17
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < NVEC; i++) step(0, 1, 4'($urandom), 1'($urandom), 0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    step(0, 1, 4'd2, 1, 0);
    chk("ovf5", 32'(overflow5), 32'd1);
    chk("count5", 32'(vec_count5), 32'd17);

    // Full FIFO with simultaneous push and pop keeps all 16 records
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < NVEC; i++) step(0, 1, 4'(i), 1'($urandom), 0);
    step(0, 1, 4'd5, 1, 1);
    chk("pushpop_no_ovf5", 32'(overflow5), 32'd0);
    chk("pushpop_count5", 32'(vec_count5), 32'd17);
    pops5 = 0;
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
    chk("occupancy5", 32'(pops5), 32'd16);

    // Randomised sweeps with random logger back-pressure and occasional restarts
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0, 1);
      for (int c = 0; c < 300 && !m_done; c++)
        step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, 4'($urandom),
             1'($urandom), $urandom_range(0, 2) != 0);
      for (int c = 0; c < 20; c++) step(0, 1, 4'($urandom), 1'($urandom), 1);
    end

    // Asynchronous reset in the middle of a sweep
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 1, 4'(i), i[0], 0);
    #3 reset = 1'b0;
    #1 model_clear(1'b0);
    check_outputs();
    #2 reset = 1'b1;
    @(posedge CK); #1;
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < NVEC; i++) step(0, 1, 4'(i), i[0], 1);
    chk("sig_after_reset", 32'(sig), 32'(clean_sig));

`ifdef RESP_GOLDEN_CMP_EN
    golden_tt = '0;
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < NVEC; i++) step(0, 1, 4'(i), (i == 3) || (i == 10), 1);
    chk("mism_count", 32'(mism_count), 32'd2);
    chk("first_mism_vec", 32'(first_mism_vec), 32'd3);
    chk("first_mism_valid", 32'(first_mism_valid), 32'd1);
    chk("pass_mism", 32'(pass), 32'd0);
`endif

    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
